// File: rtl/spi_master_ctrl.sv
// SPI Mode 0 master for 16-bit register frames {rw, addr, data}, MSB first,
// with a start/busy/done handshake toward the local test/config controller.
module spi_master_ctrl #(
    parameter int CLK_DIV    = 2,
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  sclk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  rw,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  spi_sck,
    output logic                  spi_ss_n,
    output logic                  spi_mosi,
    input  logic                  spi_miso
);

    localparam int FRAME_W = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int DIV_W   = $clog2(CLK_DIV) + 1;
    localparam int CNT_W   = $clog2(FRAME_W);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SCK_HI,
        SCK_LO,
        HOLD,
        GAP
    } state_t;

    state_t                state, state_next;
    logic [DIV_W-1:0]      div_cnt, div_next;
    logic [CNT_W-1:0]      bit_cnt, bit_next;
    logic [FRAME_W-1:0]    shift_reg, shift_next;
    logic [DATA_WIDTH-1:0] rx, rx_next;
    logic [DATA_WIDTH-1:0] rdata_next;
    logic                  busy_next, done_next;
    logic                  sck_next, ss_next, mosi_next;
    logic                  div_term;

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            rx        <= '0;
            rdata     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            spi_sck   <= 1'b0;
            spi_ss_n  <= 1'b1;
            spi_mosi  <= 1'b0;
        end else begin
            state     <= state_next;
            div_cnt   <= div_next;
            bit_cnt   <= bit_next;
            shift_reg <= shift_next;
            rx        <= rx_next;
            rdata     <= rdata_next;
            busy      <= busy_next;
            done      <= done_next;
            spi_sck   <= sck_next;
            spi_ss_n  <= ss_next;
            spi_mosi  <= mosi_next;
        end
    end

    // Every non-idle phase lasts CLK_DIV cycles; the phase ends on the divider's terminal count.
    always_comb begin
        state_next = state;
        div_next   = div_cnt;
        bit_next   = bit_cnt;
        shift_next = shift_reg;
        rx_next    = rx;
        rdata_next = rdata;
        busy_next  = busy;
        done_next  = 1'b0;
        sck_next   = spi_sck;
        ss_next    = spi_ss_n;
        mosi_next  = spi_mosi;
        div_term   = (div_cnt == DIV_W'(CLK_DIV - 1));

        if (state != IDLE) begin
            div_next = div_term ? '0 : div_cnt + 1'b1;
        end

        case (state)
            IDLE: begin
                div_next  = '0;
                bit_next  = '0;
                busy_next = 1'b0;
                sck_next  = 1'b0;
                ss_next   = 1'b1;
                mosi_next = 1'b0;
                if (start) begin
                    shift_next = {rw, addr, wdata};
                    ss_next    = 1'b0;
                    mosi_next  = rw;
                    busy_next  = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                if (div_term) begin
                    sck_next   = 1'b1;
                    state_next = SCK_HI;
                end
            end
            SCK_HI: begin
                if (div_term) begin
                    rx_next  = {rx[DATA_WIDTH-2:0], spi_miso};
                    sck_next = 1'b0;
                    // Rotating keeps the next bit at [FRAME_W-2] so MOSI only moves on the falling edge.
                    if (bit_cnt != CNT_W'(FRAME_W - 1)) begin
                        shift_next = {shift_reg[FRAME_W-2:0], shift_reg[FRAME_W-1]};
                        mosi_next  = shift_reg[FRAME_W-2];
                        state_next = SCK_LO;
                    end else begin
                        state_next = HOLD;
                    end
                end
            end
            SCK_LO: begin
                if (div_term) begin
                    sck_next   = 1'b1;
                    bit_next   = bit_cnt + 1'b1;
                    state_next = SCK_HI;
                end
            end
            HOLD: begin
                if (div_term) begin
                    ss_next    = 1'b1;
                    mosi_next  = 1'b0;
                    rdata_next = rx;
                    done_next  = 1'b1;
                    state_next = GAP;
                end
            end
            GAP: begin
                if (div_term) begin
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: CLK_DIV=2 and CLK_DIV=1 instances, each with a
// Mode 0 slave model and a scoreboard of expected MOSI frames and read-back data.
module tb_spi_master_ctrl;

    typedef struct {
        logic        rw;
        logic [6:0]  addr;
        logic [7:0]  wdata;
        logic [7:0]  miso;
        logic [15:0] exp_mosi;
        logic [7:0]  exp_rdata;
    } vec_t;

    typedef struct packed {
        logic [15:0] mosi;
        logic [7:0]  rdata;
    } exp_t;

    logic       sclk = 1'b0;
    logic       rst;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       start2, start1;
    logic [7:0] rdata2, rdata1;
    logic       busy2, busy1, done2, done1;
    logic       sck2, sck1, ss_n2, ss_n1, mosi2, mosi1;
    logic       miso2 = 1'b0;
    logic       miso1 = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    vec_t vecs[6];
    exp_t q2[$];
    exp_t q1[$];
    exp_t e2, e1;

    always #5 sclk = ~sclk;

    always @(posedge sclk) cyc <= cyc + 1;

    spi_master_ctrl #(.CLK_DIV(2), .ADDR_WIDTH(7), .DATA_WIDTH(8)) u_dut2 (
        .sclk(sclk), .rst(rst), .start(start2), .rw(rw), .addr(addr), .wdata(wdata),
        .rdata(rdata2), .busy(busy2), .done(done2), .spi_sck(sck2), .spi_ss_n(ss_n2),
        .spi_mosi(mosi2), .spi_miso(miso2)
    );

    spi_master_ctrl #(.CLK_DIV(1), .ADDR_WIDTH(7), .DATA_WIDTH(8)) u_dut1 (
        .sclk(sclk), .rst(rst), .start(start1), .rw(rw), .addr(addr), .wdata(wdata),
        .rdata(rdata1), .busy(busy1), .done(done1), .spi_sck(sck1), .spi_ss_n(ss_n1),
        .spi_mosi(mosi1), .spi_miso(miso1)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Slave models: first 8 bits return ones, bits 8..15 return s_byte on reads and 0 on writes.
    int         rises2 = 0, rises1 = 0;
    int         falls2 = 0, falls1 = 0;
    int         ss_falls2 = 0, ss_falls1 = 0;
    int         done_cnt2 = 0, done_cnt1 = 0;
    logic [15:0] cap2 = '0, cap1 = '0;
    logic       s_rw2 = 1'b0, s_rw1 = 1'b0;
    logic [7:0] s_byte2 = '0, s_byte1 = '0;

    always @(negedge ss_n2) begin
        falls2 = 0; rises2 = 0; cap2 = '0; miso2 = 1'b1; ss_falls2++;
    end
    always @(posedge sck2) begin
        if (rises2 == 0) s_rw2 = mosi2;
        cap2 = {cap2[14:0], mosi2};
        rises2++;
    end
    always @(negedge sck2) begin
        falls2++;
        miso2 = (falls2 < 8) ? 1'b1 : ((falls2 < 16 && s_rw2) ? s_byte2[15-falls2] : 1'b0);
    end

    always @(negedge ss_n1) begin
        falls1 = 0; rises1 = 0; cap1 = '0; miso1 = 1'b1; ss_falls1++;
    end
    always @(posedge sck1) begin
        if (rises1 == 0) s_rw1 = mosi1;
        cap1 = {cap1[14:0], mosi1};
        rises1++;
    end
    always @(negedge sck1) begin
        falls1++;
        miso1 = (falls1 < 8) ? 1'b1 : ((falls1 < 16 && s_rw1) ? s_byte1[15-falls1] : 1'b0);
    end

    always @(negedge sclk) begin
        if (!rst && done2) begin
            if (q2.size() == 0) begin
                check_output("done2_unexpected", 1, 0);
            end else begin
                e2 = q2.pop_front();
                check_output("mosi2", {16'h0, cap2}, {16'h0, e2.mosi});
                check_output("rdata2", {24'h0, rdata2}, {24'h0, e2.rdata});
                check_output("rises2", rises2, 16);
            end
            done_cnt2++;
        end
        if (!rst && done1) begin
            if (q1.size() == 0) begin
                check_output("done1_unexpected", 1, 0);
            end else begin
                e1 = q1.pop_front();
                check_output("mosi1", {16'h0, cap1}, {16'h0, e1.mosi});
                check_output("rdata1", {24'h0, rdata1}, {24'h0, e1.rdata});
                check_output("rises1", rises1, 16);
            end
            done_cnt1++;
        end
    end

    function automatic logic probe(input int dut, input int what);
        logic d, b;
        d = (dut == 1) ? done1 : done2;
        b = (dut == 1) ? busy1 : busy2;
        return (what == 0) ? d : !b;
    endfunction

    // what: 0 = wait for done, 1 = wait for busy low
    task automatic wait_for(input int dut, input int what, input string name, output int t);
        int n = 0;
        while (!probe(dut, what) && n < 2000) begin
            @(negedge sclk);
            n++;
        end
        if (!probe(dut, what)) check_output({name, "_timeout"}, 0, 1);
        t = cyc;
    endtask

    task automatic apply_stimulus(input int dut, input vec_t v);
        int t0, t, d;
        d = (dut == 1) ? 1 : 2;
        wait_for(dut, 1, "idle", t);
        rw    = v.rw;
        addr  = v.addr;
        wdata = v.wdata;
        if (dut == 1) begin
            s_byte1 = v.miso;
            q1.push_back({v.exp_mosi, v.exp_rdata});
            start1 = 1'b1;
        end else begin
            s_byte2 = v.miso;
            q2.push_back({v.exp_mosi, v.exp_rdata});
            start2 = 1'b1;
        end
        t0 = cyc;
        @(negedge sclk);
        start1 = 1'b0;
        start2 = 1'b0;
        rw    = ~rw;
        addr  = ~addr;
        wdata = ~wdata;
        check_output("ss_fall", (dut == 1) ? ss_n1 : ss_n2, 0);
        if (dut == 1) begin
            check_output("sck1_t1", sck1, 0);
            @(negedge sclk); check_output("sck1_t2", sck1, 1);
            @(negedge sclk); check_output("sck1_t3", sck1, 0);
            @(negedge sclk); check_output("sck1_t4", sck1, 1);
        end
        wait_for(dut, 0, "done", t);
        check_output("done_time", t - t0, 33 * d + 1);
        check_output("ss_rise_at_done", (dut == 1) ? ss_n1 : ss_n2, 1);
        @(negedge sclk);
        check_output("done_pulse", (dut == 1) ? done1 : done2, 0);
        wait_for(dut, 1, "busy", t);
        check_output("busy_time", t - t0, 34 * d + 1);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t0, t, hi, tf, n, dc, sf;
        logic prev;

        vecs[0] = '{1'b0, 7'h2A, 8'hC3, 8'h5A, 16'h2AC3, 8'h00};
        vecs[1] = '{1'b1, 7'h05, 8'h00, 8'hA5, 16'h8500, 8'hA5};
        vecs[2] = '{1'b1, 7'h7F, 8'hFF, 8'h00, 16'hFFFF, 8'h00};
        vecs[3] = '{1'b0, 7'h00, 8'h00, 8'hFF, 16'h0000, 8'h00};
        vecs[4] = '{1'b1, 7'h55, 8'hAA, 8'h3C, 16'hD5AA, 8'h3C};
        vecs[5] = '{1'b1, 7'h01, 8'h80, 8'h81, 16'h8180, 8'h81};

        rst = 1'b1; start2 = 1'b0; start1 = 1'b0;
        rw = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(negedge sclk);
        check_output("rst_ss_n", ss_n2, 1);
        check_output("rst_sck", sck2, 0);
        check_output("rst_mosi", mosi2, 0);
        check_output("rst_busy", busy2, 0);
        check_output("rst_done", done2, 0);
        check_output("rst_rdata", rdata2, 0);
        rst = 1'b0;
        @(negedge sclk);

        for (int i = 0; i < 6; i++) apply_stimulus(2, vecs[i]);

        // Reset at the 7th SCK rise aborts the frame and clears rdata (0x81 before).
        rw = 1'b1; addr = 7'h12; wdata = 8'h34; s_byte2 = 8'hFF;
        q2.push_back({16'h9234, 8'hFF});
        start2 = 1'b1;
        @(negedge sclk);
        start2 = 1'b0;
        n = 0;
        while (rises2 != 7 && n < 500) begin @(negedge sclk); n++; end
        check_output("rst_wait_rise7", rises2, 7);
        check_output("pre_rst_mosi", mosi2, 1);
        dc = done_cnt2;
        rst = 1'b1;
        #1;
        check_output("midrst_ss_n", ss_n2, 1);
        check_output("midrst_sck", sck2, 0);
        check_output("midrst_mosi", mosi2, 0);
        check_output("midrst_busy", busy2, 0);
        check_output("midrst_rdata", rdata2, 0);
        q2.delete();
        @(negedge sclk);
        rst = 1'b0;
        repeat (80) @(negedge sclk);
        check_output("midrst_no_done", done_cnt2 - dc, 0);
        check_output("midrst_rdata_hold", rdata2, 0);
        apply_stimulus(2, vecs[1]);

        // Second start pulse mid-frame must be ignored.
        dc = done_cnt2;
        sf = ss_falls2;
        rw = 1'b0; addr = 7'h11; wdata = 8'h22; s_byte2 = 8'h77;
        q2.push_back({16'h1122, 8'h00});
        start2 = 1'b1;
        t0 = cyc;
        @(negedge sclk);
        start2 = 1'b0;
        rw = 1'b1; addr = 7'h7F;
        while (cyc < t0 + 10) @(negedge sclk);
        start2 = 1'b1;
        @(negedge sclk);
        start2 = 1'b0;
        wait_for(2, 0, "ign_done", t);
        repeat (150) @(negedge sclk);
        check_output("ign_done_count", done_cnt2 - dc, 1);
        check_output("ign_ss_falls", ss_falls2 - sf, 1);

        // start held high: back-to-back frames separated by the GAP.
        rw = 1'b1; addr = 7'h33; wdata = 8'h44; s_byte2 = 8'h96;
        q2.push_back({16'hB344, 8'h96});
        q2.push_back({16'h6C0F, 8'h00});
        start2 = 1'b1;
        t0 = cyc;
        @(negedge sclk);
        rw = 1'b0; addr = 7'h6C; wdata = 8'h0F;
        prev = ss_n2;
        hi = 0;
        tf = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge sclk);
            if (ss_n2) begin
                hi++;
            end else if (prev) begin
                tf = cyc;
                break;
            end
            prev = ss_n2;
        end
        start2 = 1'b0;
        check_output("b2b_ss_fall", tf - t0, 70);
        check_output("b2b_gap_cycles", hi, 3);
        wait_for(2, 0, "b2b_done", t);
        @(negedge sclk);
        wait_for(2, 1, "b2b_idle", t);

        // CLK_DIV=1 instance: read 0x3C and a write.
        apply_stimulus(1, '{1'b1, 7'h40, 8'h00, 8'h3C, 16'hC000, 8'h3C});
        apply_stimulus(1, '{1'b0, 7'h7E, 8'h99, 8'h3C, 16'h7E99, 8'h00});

        repeat (5) @(negedge sclk);
        check_output("q2_drained", q2.size(), 0);
        check_output("q1_drained", q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
